seq_subtractor: RTL and testbench

- Multi-cycle, parametrised successor to the 1-bit full-subtractor cell.
- Computes DIFF = A - B - BIN over WIDTH bits, CHUNK bits per clock, LSB chunk first.
- The borrow is registered between chunks.
- Sits between operand producers and consumers behind valid/ready handshakes, for area-constrained datapaths where a full WIDTH-bit ripple chain per cycle is not wanted.

---
 rtl/seq_sub_pkg.sv | 23 ++
 rtl/seq_subtractor_if.sv | 26 ++
 rtl/seq_subtractor_sub_chunk.sv | 28 ++
 rtl/seq_subtractor.sv | 118 +++++++++++
 tb/tb_seq_subtractor.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_sub_pkg.sv
// Shared types and sizing helpers for the chunked sequential subtractor.
package seq_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int cnt_width(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_subtractor_if.sv
// Operand/result handshake bundle for seq_subtractor.
// master = operand producer + result consumer, slave = subtractor.
interface seq_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BIN;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] DIFF;
  logic             BOUT;
  logic             OVF;

  modport master (
    output in_valid, A, B, BIN, out_ready,
    input  in_ready, out_valid, DIFF, BOUT, OVF
  );

  modport slave (
    input  in_valid, A, B, BIN, out_ready,
    output in_ready, out_valid, DIFF, BOUT, OVF
  );
endinterface

// File: rtl/seq_subtractor_sub_chunk.sv
// Combinational CHUNK-bit ripple of full-subtractor cells.
// o_bmsb is the borrow into the top cell, used for signed overflow.
module sub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_bin,
  output logic [CHUNK-1:0] o_diff,
  output logic             o_bout,
  output logic             o_bmsb
);
  logic [CHUNK:0] w_brw;

  always_comb begin
    w_brw    = '0;
    o_diff   = '0;
    w_brw[0] = i_bin;
    for (int i = 0; i < CHUNK; i++) begin
      o_diff[i]  = i_a[i] ^ i_b[i] ^ w_brw[i];
      w_brw[i+1] = (~i_a[i] & i_b[i]) |
                   (~(i_a[i] ^ i_b[i]) & w_brw[i]);
    end
  end

  assign o_bout = w_brw[CHUNK];
  assign o_bmsb = w_brw[CHUNK-1];
endmodule

// File: rtl/seq_subtractor.sv
// Multi-cycle DIFF = A - B - BIN, CHUNK bits per clock, LSB chunk first.
// Define SEQ_SUB_SAT_EN to force DIFF to zero when the result borrows out.
module seq_subtractor
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input logic             clk,
  input logic             rst,
  seq_subtractor_if.slave bus
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = cnt_width(WIDTH, CHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_idx;
  logic             r_borrow;
  logic             r_bout;
  logic             r_ovf;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_last;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK-1:0] w_cd;
  logic             w_cbout;
  logic             w_cbmsb;

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_last   = (r_idx == LAST);

  always_comb begin
    w_ca = '0;
    w_cb = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (r_idx == CW'(k)) begin
        w_ca = r_a[k*CHUNK +: CHUNK];
        w_cb = r_b[k*CHUNK +: CHUNK];
      end
    end
  end

  sub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .i_a    (w_ca),
    .i_b    (w_cb),
    .i_bin  (r_borrow),
    .o_diff (w_cd),
    .o_bout (w_cbout),
    .o_bmsb (w_cbmsb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid) w_next = BUSY;
      BUSY:    if (w_last) w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == IDLE);
    w_out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.A;
      r_b      <= bus.B;
      r_borrow <= bus.BIN;
      r_idx    <= '0;
    end else if (r_state == BUSY) begin
      for (int k = 0; k < NCHUNK; k++) begin
        if (r_idx == CW'(k)) r_diff[k*CHUNK +: CHUNK] <= w_cd;
      end
      r_borrow <= w_cbout;
      r_idx    <= r_idx + CW'(1);
      if (w_last) begin
        r_bout <= w_cbout;
        r_ovf  <= w_cbmsb ^ w_cbout;
`ifdef SEQ_SUB_SAT_EN
        // Later assignment wins over the final chunk write above.
        if (w_cbout) r_diff <= '0;
`endif
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.DIFF      = r_diff;
  assign bus.BOUT      = r_bout;
  assign bus.OVF       = r_ovf;
endmodule

// File: tb/tb_seq_subtractor.sv
// Bench for seq_subtractor: directed cases on 16/4 plus random runs on
// 16/4, 16/1, 8/8 and 32/8 against an integer arithmetic model.
module tb_seq_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sel;

  logic        t_in_valid;
  logic        t_bin;
  logic        t_out_ready;
  logic [31:0] t_a;
  logic [31:0] t_b;

  logic        m_in_ready;
  logic        m_out_valid;
  logic        m_bout;
  logic        m_ovf;
  logic [31:0] m_diff;

  seq_subtractor_if #(.WIDTH(16)) if0 ();
  seq_subtractor_if #(.WIDTH(16)) if1 ();
  seq_subtractor_if #(.WIDTH(8))  if2 ();
  seq_subtractor_if #(.WIDTH(32)) if3 ();

  assign if0.in_valid  = t_in_valid && (sel == 0);
  assign if0.out_ready = t_out_ready && (sel == 0);
  assign if0.A         = t_a[15:0];
  assign if0.B         = t_b[15:0];
  assign if0.BIN       = t_bin;

  assign if1.in_valid  = t_in_valid && (sel == 1);
  assign if1.out_ready = t_out_ready && (sel == 1);
  assign if1.A         = t_a[15:0];
  assign if1.B         = t_b[15:0];
  assign if1.BIN       = t_bin;

  assign if2.in_valid  = t_in_valid && (sel == 2);
  assign if2.out_ready = t_out_ready && (sel == 2);
  assign if2.A         = t_a[7:0];
  assign if2.B         = t_b[7:0];
  assign if2.BIN       = t_bin;

  assign if3.in_valid  = t_in_valid && (sel == 3);
  assign if3.out_ready = t_out_ready && (sel == 3);
  assign if3.A         = t_a;
  assign if3.B         = t_b;
  assign if3.BIN       = t_bin;

  seq_subtractor #(.WIDTH(16), .CHUNK(4)) u0 (
    .clk (clk), .rst (rst), .bus (if0.slave));
  seq_subtractor #(.WIDTH(16), .CHUNK(1)) u1 (
    .clk (clk), .rst (rst), .bus (if1.slave));
  seq_subtractor #(.WIDTH(8),  .CHUNK(8)) u2 (
    .clk (clk), .rst (rst), .bus (if2.slave));
  seq_subtractor #(.WIDTH(32), .CHUNK(8)) u3 (
    .clk (clk), .rst (rst), .bus (if3.slave));

  always_comb begin
    m_in_ready  = 1'b0;
    m_out_valid = 1'b0;
    m_diff      = '0;
    m_bout      = 1'b0;
    m_ovf       = 1'b0;
    case (sel)
      0: begin
        m_in_ready = if0.in_ready; m_out_valid = if0.out_valid;
        m_diff = {16'h0, if0.DIFF}; m_bout = if0.BOUT; m_ovf = if0.OVF;
      end
      1: begin
        m_in_ready = if1.in_ready; m_out_valid = if1.out_valid;
        m_diff = {16'h0, if1.DIFF}; m_bout = if1.BOUT; m_ovf = if1.OVF;
      end
      2: begin
        m_in_ready = if2.in_ready; m_out_valid = if2.out_valid;
        m_diff = {24'h0, if2.DIFF}; m_bout = if2.BOUT; m_ovf = if2.OVF;
      end
      default: begin
        m_in_ready = if3.in_ready; m_out_valid = if3.out_valid;
        m_diff = if3.DIFF; m_bout = if3.BOUT; m_ovf = if3.OVF;
      end
    endcase
  end

  function automatic int width_of(input int s);
    case (s)
      0: return 16;
      1: return 16;
      2: return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int chunk_of(input int s);
    case (s)
      0: return 4;
      1: return 1;
      2: return 8;
      default: return 8;
    endcase
  endfunction

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input int w, input logic [31:0] a,
                                input logic [31:0] b, input logic bin,
                                output logic [31:0] d, output logic bo,
                                output logic ov);
    longint m, ua, ub, sa, sb, full, sfull;
    m     = longint'(1) << w;
    ua    = longint'(a);
    ub    = longint'(b);
    full  = ua - ub - longint'(bin);
    bo    = (full < 0);
    d     = 32'(full & (m - 1));
    sa    = (ua >= m / 2) ? ua - m : ua;
    sb    = (ub >= m / 2) ? ub - m : ub;
    sfull = sa - sb - longint'(bin);
    ov    = (sfull < -(m / 2)) || (sfull > (m / 2 - 1));
`ifdef SEQ_SUB_SAT_EN
    if (bo) d = '0;
`endif
  endfunction

  // Latency counts the accepting edge as edge 1.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic bin, input int rdly, input bit noise,
                        output logic [31:0] d, output logic bo,
                        output logic ov, output int lat);
    int n;
    t_a = a; t_b = b; t_bin = bin; t_in_valid = 1'b1;
    n = 0;
    while (!m_in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    t_in_valid = 1'b0;
    t_a = $urandom; t_b = $urandom; t_bin = 1'($urandom);
    lat = 1;
    while (!m_out_valid && lat < 200) begin
      t_out_ready = noise ? 1'($urandom) : 1'b0;
      @(negedge clk);
      lat++;
    end
    t_out_ready = 1'b0;
    d = m_diff; bo = m_bout; ov = m_ovf;
    repeat (rdly) @(negedge clk);
    t_out_ready = 1'b1;
    @(negedge clk);
    t_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    sel = 0;
    rst = 1'b1;
    t_in_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (m_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", m_in_ready);
    end
    checks++;
    if (m_out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got %b want 0", m_out_valid);
    end
    checks++;
    if (m_diff !== 32'h0) begin
      errors++; $display("FAIL reset_diff got %h want 0", m_diff);
    end
    checks++;
    if (m_bout !== 1'b0 || m_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got bout=%b ovf=%b want 0 0", m_bout, m_ovf);
    end
    t_in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset got in_ready=%b out_valid=%b want 1 0",
               m_in_ready, m_out_valid);
    end
  endtask

  task automatic test_directed;
    logic [31:0] d;
    logic [31:0] e;
    logic bo, ov;
    int lat;
    sel = 0;
    run_op(32'h1234, 32'h0234, 1'b0, 0, 1'b0, d, bo, ov, lat);
    checks++;
    if (lat != 5) begin
      errors++; $display("FAIL t1_latency got %0d edges want 5", lat);
    end
    checks++;
    if (d !== 32'h1000 || bo !== 1'b0 || ov !== 1'b0) begin
      errors++;
      $display("FAIL t1_result got %h/%b/%b want 00001000/0/0", d, bo, ov);
    end
`ifdef SEQ_SUB_SAT_EN
    e = 32'h0;
`else
    e = 32'hFFFF;
`endif
    run_op(32'h0000, 32'h0001, 1'b0, 1, 1'b0, d, bo, ov, lat);
    checks++;
    if (d !== e || bo !== 1'b1 || ov !== 1'b0) begin
      errors++;
      $display("FAIL t2_wrap got %h/%b/%b want %h/1/0", d, bo, ov, e);
    end
    run_op(32'h8000, 32'h0001, 1'b0, 0, 1'b0, d, bo, ov, lat);
    checks++;
    if (d !== 32'h7FFF || bo !== 1'b0 || ov !== 1'b1) begin
      errors++;
      $display("FAIL t3_ovf got %h/%b/%b want 00007fff/0/1", d, bo, ov);
    end
    run_op(32'h0005, 32'h0005, 1'b1, 2, 1'b0, d, bo, ov, lat);
    checks++;
    if (d !== e || bo !== 1'b1 || ov !== 1'b0) begin
      errors++;
      $display("FAIL t3_bin got %h/%b/%b want %h/1/0", d, bo, ov, e);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] d;
    logic bo, ov;
    int lat, n;
    sel = 0;
    t_a = 32'h4321; t_b = 32'h1111; t_bin = 1'b0; t_in_valid = 1'b1;
    @(negedge clk);
    t_in_valid = 1'b0;
    n = 0;
    while (!m_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    t_a = 32'h0100; t_b = 32'h0001; t_bin = 1'b1; t_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0 ||
          m_diff !== 32'h3210 || m_bout !== 1'b0 || m_ovf !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d got v=%b r=%b d=%h b=%b o=%b want 1 0 3210 0 0",
                 i, m_out_valid, m_in_ready, m_diff, m_bout, m_ovf);
      end
      @(negedge clk);
    end
    t_out_ready = 1'b1;
    @(negedge clk);
    t_out_ready = 1'b0;
    checks++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release got in_ready=%b out_valid=%b want 1 0",
               m_in_ready, m_out_valid);
    end
    run_op(32'h0100, 32'h0001, 1'b1, 0, 1'b0, d, bo, ov, lat);
    checks++;
    if (d !== 32'h00FE || bo !== 1'b0 || ov !== 1'b0 || lat != 5) begin
      errors++;
      $display("FAIL second_op got %h/%b/%b lat %0d want 000000fe/0/0 lat 5",
               d, bo, ov, lat);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic bo, ov;
    int lat, seen;
    sel = 0;
    t_a = 32'hABCD; t_b = 32'h1234; t_bin = 1'b0; t_in_valid = 1'b1;
    @(negedge clk);
    t_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0 || m_diff !== 32'h0 ||
        m_bout !== 1'b0 || m_ovf !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got r=%b v=%b d=%h b=%b o=%b want 1 0 0 0 0",
               m_in_ready, m_out_valid, m_diff, m_bout, m_ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    t_out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_out_valid) seen++;
    end
    t_out_ready = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL no_valid_after_reset got %0d want 0", seen);
    end
    run_op(32'h00FF, 32'h000F, 1'b0, 0, 1'b0, d, bo, ov, lat);
    checks++;
    if (d !== 32'h00F0 || bo !== 1'b0 || ov !== 1'b0 || lat != 5) begin
      errors++;
      $display("FAIL after_reset_op got %h/%b/%b lat %0d want 000000f0/0/0 lat 5",
               d, bo, ov, lat);
    end
  endtask

  task automatic test_random(input int s, input int nops);
    logic [31:0] mask, a, b, d, ed;
    logic bin, bo, ov, eb, eo;
    int w, nc, lat;
    w  = width_of(s);
    nc = w / chunk_of(s);
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    sel = s;
    @(negedge clk);
    for (int i = 0; i < nops; i++) begin
      a = $urandom & mask;
      b = $urandom & mask;
      bin = 1'($urandom);
      case (i % 8)
        0: a = '0;
        1: b = mask;
        2: b = a;
        default: ;
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_op(a, b, bin, $urandom_range(0, 2), 1'b1, d, bo, ov, lat);
      model(w, a, b, bin, ed, eb, eo);
      checks++;
      if (d !== ed || bo !== eb || ov !== eo || lat != nc + 1) begin
        errors++;
        $display("FAIL rnd_w%0d_c%0d a=%h b=%h bin=%b got %h/%b/%b lat %0d want %h/%b/%b lat %0d",
                 w, chunk_of(s), a, b, bin, d, bo, ov, lat, ed, eb, eo, nc + 1);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    sel = 0;
    t_in_valid = 1'b0;
    t_out_ready = 1'b0;
    t_a = '0;
    t_b = '0;
    t_bin = 1'b0;
    test_reset;
    test_directed;
    test_backpressure;
    test_reset_mid;
    test_random(0, 400);
    test_random(1, 400);
    test_random(2, 400);
    test_random(3, 400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
